// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 adder normalize/round stage.
// Optional feature macro: FP16_ADD_RNE_EN (round-to-nearest-even; truncation when undefined).
package fp16_pkg;

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned MANT_W = 10;
  localparam int unsigned FRAC_W = 13;
  localparam int unsigned BIAS   = 15;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
  localparam logic [15:0]      POS_INF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;

  typedef enum logic [1:0] {
    NC_NORMAL,
    NC_ZERO,
    NC_UNF,
    NC_INF
  } norm_class_t;

endpackage

// File: rtl/fp16_add_normalize_lzc13.sv
// Combinational 13-bit leading-zero counter; count is 13 when the input is zero.
module lzc13 (
  input  logic [12:0] value,
  output logic [3:0]  count
);

  logic found;

  // Scan from the MSB down, latching the position of the first set bit.
  always_comb begin
    count = 4'd13;
    found = 1'b0;
    for (int i = 12; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 4'(12 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_add_normalize.sv
// FP16 adder stage 3: normalize (stage A) then round and pack (stage B).
// Optional feature macro: FP16_ADD_RNE_EN selects round-to-nearest-even;
// when undefined the mantissa is truncated.
module fp16_add_normalize (
  input  logic        clk,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [12:0] sum_in,
  input  logic        carry_in,
  input  logic [4:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf_flag,
  output logic        unf_flag
);
  import fp16_pkg::*;

  logic [3:0]            lzc;
  logic signed [6:0]     exp_sh;
  logic                  n_sign;
  logic [FRAC_W-1:0]     n_v;
  logic signed [6:0]     n_exp;
  norm_class_t           n_cls;

  logic                  a_valid;
  logic                  a_sign;
  logic [FRAC_W-1:0]     a_v;
  logic signed [6:0]     a_exp;
  norm_class_t           a_cls;

  logic                  b_valid;
  logic                  b_load;
  fp16_t                 res_n;
  fp16_t                 res_q;
  logic                  ovf_n;
  logic                  unf_n;
  logic                  ovf_q;
  logic                  unf_q;
  logic [MANT_W-1:0]     mant_r;
  logic signed [6:0]     exp_r;

  lzc13 u_lzc (
    .value (sum_in),
    .count (lzc)
  );

  assign b_load    = !b_valid || out_ready;
  assign in_ready  = !a_valid || b_load;
  assign out_valid = b_valid;
  assign result    = res_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;

  // Normalize the raw sum and classify it.
  always_comb begin
    n_sign = sign_in;
    n_v    = '0;
    n_exp  = '0;
    n_cls  = NC_NORMAL;
    exp_sh = 7'({2'b00, exp_in}) - 7'({3'b000, lzc});
    if (exp_in == EXP_MAX) begin
      n_cls = NC_INF;
    end else if (carry_in) begin
      // Right shift by one; the dropped bit folds into sticky.
      n_v   = {1'b1, sum_in[12:2], sum_in[1] | sum_in[0]};
      n_exp = 7'({2'b00, exp_in}) + 7'sd1;
    end else if (sum_in == '0) begin
      n_sign = 1'b0;
      n_cls  = NC_ZERO;
    end else begin
      n_v   = sum_in << lzc;
      n_exp = exp_sh;
      if (exp_sh <= 7'sd0) n_cls = NC_UNF;
    end
  end

  // Stage A register: normalized value and class.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      a_valid <= 1'b0;
      a_sign  <= 1'b0;
      a_v     <= '0;
      a_exp   <= '0;
      a_cls   <= NC_ZERO;
    end else if (in_ready) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_sign <= n_sign;
        a_v    <= n_v;
        a_exp  <= n_exp;
        a_cls  <= n_cls;
      end
    end
  end

`ifdef FP16_ADD_RNE_EN
  logic [MANT_W:0] rnd;
  logic            unused_bits;
  assign unused_bits = a_v[12];
`else
  logic            unused_bits;
  assign unused_bits = ^{a_v[12], a_v[1:0]};
`endif

  // Round the stage A value and pack the binary16 result with its flags.
  always_comb begin
    res_n  = '0;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    mant_r = a_v[11:2];
    exp_r  = a_exp;
`ifdef FP16_ADD_RNE_EN
    rnd = {1'b0, a_v[11:2]} + 11'(a_v[1] & (a_v[0] | a_v[2]));
    if (rnd[MANT_W]) begin
      mant_r = '0;
      exp_r  = a_exp + 7'sd1;
    end else begin
      mant_r = rnd[MANT_W-1:0];
    end
`endif
    case (a_cls)
      NC_ZERO: res_n.sign = a_sign;
      NC_UNF: begin
        res_n.sign = a_sign;
        unf_n      = 1'b1;
      end
      NC_INF: begin
        res_n      = fp16_t'(POS_INF);
        res_n.sign = a_sign;
        ovf_n      = 1'b1;
      end
      default: begin
        if (exp_r >= 7'sd31) begin
          res_n      = fp16_t'(POS_INF);
          res_n.sign = a_sign;
          ovf_n      = 1'b1;
        end else begin
          res_n.sign = a_sign;
          res_n.exp  = 5'(exp_r);
          res_n.mant = mant_r;
        end
      end
    endcase
  end

  // Stage B register: drives the outputs directly, holds while stalled.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      b_valid <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (b_load) begin
      b_valid <= a_valid;
      if (a_valid) begin
        res_q <= res_n;
        ovf_q <= ovf_n;
        unf_q <= unf_n;
      end
    end
  end

endmodule

// File: tb/tb_fp16_add_normalize.sv
// Scoreboard bench for fp16_add_normalize: driver pushes expected results,
// negedge monitor pops and compares on each output transfer.
module tb_fp16_add_normalize;

  logic        clk;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [12:0] sum_in;
  logic        carry_in;
  logic [4:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf_flag;
  logic        unf_flag;

  typedef struct packed {
    logic [15:0] r;
    logic        o;
    logic        u;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic        stalled = 1'b0;
  logic [17:0] held = '0;

  fp16_add_normalize dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Call at #1 after a posedge; returns #1 after the transfer edge.
  task automatic send(input logic s, input logic [12:0] m, input logic c, input logic [4:0] e,
                      input logic [15:0] r, input logic o, input logic u);
    int t;
    t        = 0;
    sign_in  = s;
    sum_in   = m;
    carry_in = c;
    exp_in   = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck low for sum %h", m);
    end else begin
      q.push_back('{r: r, o: o, u: u});
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: check each accepted output against the queue; check hold under stall.
  always @(negedge clk) begin
    if (!nRST) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        total++;
        if ({result, ovf_flag, unf_flag} !== held) begin
          bad++;
          $display("FAIL stall_hold: got %h expected %h", {result, ovf_flag, unf_flag}, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = {result, ovf_flag, unf_flag};
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: result %h with empty scoreboard", result);
        end else begin
          exp_t x;
          x = q.pop_front();
          if ({result, ovf_flag, unf_flag} !== {x.r, x.o, x.u}) begin
            bad++;
            $display("FAIL result: got %h ovf=%b unf=%b expected %h ovf=%b unf=%b",
                     result, ovf_flag, unf_flag, x.r, x.o, x.u);
          end
        end
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results never emerged", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    nRST      = 1'b0;
    in_valid  = 1'b0;
    sign_in   = 1'b0;
    sum_in    = '0;
    carry_in  = 1'b0;
    exp_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_ovf", 32'(ovf_flag), 32'd0);
    chk("reset_unf", 32'(unf_flag), 32'd0);
    nRST = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Carry path with latency check: 1.5 + 1.5 = 3.0
    send(1'b0, 13'h1000, 1'b1, 5'd15, 16'h4200, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("latency_edge1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_edge2", 32'(out_valid), 32'd1);
    drain();

    send(1'b1, 13'h0400, 1'b0, 5'd15, 16'hB400, 1'b0, 1'b0);
    send(1'b1, 13'h0000, 1'b0, 5'd15, 16'h0000, 1'b0, 1'b0);
    send(1'b0, 13'h0000, 1'b1, 5'd15, 16'h4000, 1'b0, 1'b0);
`ifdef FP16_ADD_RNE_EN
    send(1'b0, 13'h1007, 1'b0, 5'd15, 16'h3C02, 1'b0, 1'b0);
    send(1'b0, 13'h1002, 1'b0, 5'd15, 16'h3C00, 1'b0, 1'b0);
    send(1'b0, 13'h1006, 1'b0, 5'd15, 16'h3C02, 1'b0, 1'b0);
    send(1'b0, 13'h1FFF, 1'b0, 5'd30, 16'h7C00, 1'b1, 1'b0);
`else
    send(1'b0, 13'h1007, 1'b0, 5'd15, 16'h3C01, 1'b0, 1'b0);
    send(1'b0, 13'h1002, 1'b0, 5'd15, 16'h3C00, 1'b0, 1'b0);
    send(1'b0, 13'h1006, 1'b0, 5'd15, 16'h3C01, 1'b0, 1'b0);
    send(1'b0, 13'h1FFF, 1'b0, 5'd30, 16'h7BFF, 1'b0, 1'b0);
`endif
    send(1'b0, 13'h1FFF, 1'b1, 5'd30, 16'h7C00, 1'b1, 1'b0);
    send(1'b0, 13'h0001, 1'b0, 5'd5,  16'h0000, 1'b0, 1'b1);
    send(1'b1, 13'h0001, 1'b0, 5'd5,  16'h8000, 1'b0, 1'b1);
    send(1'b1, 13'h1000, 1'b0, 5'd31, 16'hFC00, 1'b1, 1'b0);
    send(1'b0, 13'h0800, 1'b0, 5'd1,  16'h0000, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: three back-to-back inputs with the output stalled.
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        send(1'b0, 13'h1000, 1'b1, 5'd15, 16'h4200, 1'b0, 1'b0);
        send(1'b1, 13'h0400, 1'b0, 5'd15, 16'hB400, 1'b0, 1'b0);
        send(1'b0, 13'h1800, 1'b0, 5'd16, 16'h4200, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepted", 32'(acc_cnt), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_result_held", 32'(result), 32'h4200);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_accepted", 32'(acc_cnt), 32'd3);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(1'b0, 13'h0400, 1'b0, 5'd15, 16'h3400, 1'b0, 1'b0);
    send(1'b1, 13'h1000, 1'b1, 5'd15, 16'hC200, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    nRST = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_flags", 32'({ovf_flag, unf_flag}), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    nRST      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 13'h1000, 1'b1, 5'd15, 16'h4200, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("post_rst_edge1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_edge2", 32'(out_valid), 32'd1);
    chk("post_rst_result", 32'(result), 32'h4200);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_add_normalize.md
Name: fp16_add_normalize

Overview:
- Third stage of the FP16 adder in the systolic-array MAC unit.
- Consumes the raw signed-magnitude sum from the fraction-add stage: sign, 13-bit magnitude, carry-out and max exponent.
- Normalizes, rounds and packs the IEEE-754 binary16 result.
- Two-stage registered pipeline with valid/ready handshakes on both sides.

Parameters:
- FRAC_W, 13, width of incoming magnitude: bit 12 hidden, [11:2] mantissa, [1] guard, [0] sticky.
- EXP_W, 5, exponent width.
- BIAS, 15, exponent bias.

Ports:
- clk  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream sum valid.
- in_ready  output  1  stage can accept a sum this cycle.
- sign_in  input  1  sign of sum.
- sum_in  input  13  magnitude of sum, excluding carry.
- carry_in  input  1  magnitude overflowed bit 12.
- exp_in  input  5  max exponent from upstream.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  16  packed FP16 {sign, exp[4:0], mant[9:0]}.
- ovf_flag  output  1  result saturated to infinity.
- unf_flag  output  1  nonzero result flushed to zero.

Behaviour:
- Reset: all stage valid bits clear; out_valid=0, result=16'h0000, ovf_flag=0, unf_flag=0. in_ready=1 as soon as nRST deasserts. Reset mid-operation discards in-flight data, with no partial output.
- Handshake:
  - Transfer on valid&ready. Stage A loads when in_valid&in_ready.
  - in_ready = !A_valid | (!B_valid | out_ready).
  - Stage B loads from A when !B_valid | out_ready.
  - Outputs come directly from B registers and stay stable while out_valid&!out_ready.
  - Throughput is 1/cycle. Latency is 2 cycles from input transfer to out_valid with out_ready held high.
  - Order is preserved. No combinational path from in_valid to out_valid.
- Stage A (normalize):
  - carry_in=1: 14-bit value {1,sum_in} shifted right 1; bit shifted out ORed into sticky; exp = exp_in+1. Applies even when sum_in==0.
  - carry_in=0 and sum_in==0: zero result, forced +0 (sign cleared), no flag.
  - Otherwise: lzc = leading-zero count of sum_in (0..12); value <<= lzc; exp = exp_in - lzc, computed in a 7-bit signed intermediate.
  - exp<=0 after normalize: flush to signed zero, set unf_flag.
  - exp_in==31 on input: result is signed infinity, set ovf_flag.
  - Stage A registers sign, 13-bit normalized value, 7-bit exp and class {normal, zero, unf, inf}.
- Stage B (round/pack):
  - Round to nearest even: lsb=v[2], g=v[1], s=v[0]; increment when g&(s|lsb).
  - Mantissa increment carry out of 11 bits: mant=0, exp+1.
  - exp>=31 after rounding: result={sign,5'h1F,10'h0}, set ovf_flag.
  - Flags are per-result, valid only with out_valid.
  - Subnormal outputs are never produced.

Optional Feature:
- Macro: FP16_ADD_RNE_EN.
- Defined: round-to-nearest-even as specified in Stage B.
- Undefined: truncation (g and s ignored, no increment). Rounding-carry logic removed; overflow still detected from the exponent alone.

Decomposition:
- Package fp16_pkg holds:
  - constants EXP_W, MANT_W=10, FRAC_W, BIAS, EXP_MAX=5'h1F, POS_INF=16'h7C00;
  - typedef fp16_t (packed struct sign/exp/mant);
  - enum norm_class_t {NC_NORMAL, NC_ZERO, NC_UNF, NC_INF}.
- One sub-module: lzc13, a combinational 13-bit leading-zero counter with 4-bit count output (13 on all-zero).

Test Plan:
- Carry path: sign_in=0, sum_in=13'h1000, carry_in=1, exp_in=15 (1.5+1.5) -> result=16'h4200, flags 0, out_valid exactly 2 cycles after transfer.
- Left normalize: sign_in=1, sum_in=13'h0400, carry_in=0, exp_in=15 -> result=16'hB400 (-0.25). Then sum_in=0, sign_in=1 -> result=16'h0000, no flags.
- Rounding, exp_in=15:
  - sum_in=13'h1007 -> 16'h3C02 with RNE, 16'h3C01 with macro undefined.
  - sum_in=13'h1002 -> 16'h3C00 (tie to even, down).
  - sum_in=13'h1006 -> 16'h3C02 (tie to even, up).
- Exponent limits:
  - sum_in=13'h1FFF, carry_in=1, exp_in=30 -> 16'h7C00, ovf_flag=1.
  - sum_in=13'h0001, exp_in=5 -> 16'h0000, unf_flag=1.
- Backpressure: out_ready=0, drive 3 back-to-back inputs -> in_ready drops after 2 accepted, result held stable. Raise out_ready -> all 3 results emerge in order, none lost or duplicated.
- Reset mid-stream: assert nRST low asynchronously with both stages full -> out_valid=0, result=0 immediately; first post-reset input produces a correct result after 2 cycles.
